// File: rtl/bitrev_reorder_pkg.sv
// Shared types and helpers for the FFT output reorder stage.
// fpt is the native Q16.16 fixed-point sample type; cpx packs [1]=real, [0]=imag.
package bitrev_reorder_pkg;

  typedef logic signed [31:0] fpt;
  typedef fpt [1:0] cpx;

  // Widest index the bit-reversal helper supports.
  localparam int BITREV_MAX_N = 16;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wstate_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rstate_t;

  // Reverse the low n bits of idx; bits at and above n come back as zero.
  function automatic logic [BITREV_MAX_N-1:0] bitrev(
    input logic [BITREV_MAX_N-1:0] idx,
    input int                      n
  );
    logic [BITREV_MAX_N-1:0] res;
    res = '0;
    for (int i = 0; i < BITREV_MAX_N; i++) begin
      for (int j = 0; j < BITREV_MAX_N; j++) begin
        if ((i < n) && (j < n) && ((i + j) == (n - 1))) begin
          res[i] = idx[j];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bitrev_reorder_pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one asynchronous read port.
// Bank contents are deliberately not reset.
module pingpong_ram
  import bitrev_reorder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         i_wsel,
  input  logic [N-1:0] i_waddr,
  input  cpx           i_wdata,
  input  logic         i_we,
  input  logic         i_rsel,
  input  logic [N-1:0] i_raddr,
  output cpx           o_rdata
);

  cpx r_mem [2][2**N];

  // Store one sample into the selected bank when the write side asks for it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wsel][i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_rsel][i_raddr];

endmodule

// File: rtl/bitrev_reorder.sv
// Output reorder stage: writes each bit-reversed frame into one bank of a
// ping-pong store and drains the other bank in natural order, one sample per clock.
module bitrev_reorder
  import bitrev_reorder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  fpt [1:0] ip,
  input  logic     start_ip,
  output fpt [1:0] op,
  output logic     start_op,
  output logic     valid_op,
  output logic     abort_op
);

  localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

  wstate_t      r_wstate, w_wstate_nxt;
  logic [N-1:0] r_wcnt, w_wcnt_nxt;
  logic         r_wsel, w_wsel_nxt;
  logic         w_we;
  logic [N-1:0] w_waddr;
  logic         w_req;
  logic         w_abort;

  rstate_t      r_rstate, w_rstate_nxt;
  logic [N-1:0] r_rcnt, w_rcnt_nxt;
  logic         r_rsel, w_rsel_nxt;
  cpx           w_rdata;

  cpx           r_op, w_op_nxt;
  logic         r_start_op, w_start_op_nxt;
  logic         r_valid_op, w_valid_op_nxt;
  logic         r_abort_op;

  pingpong_ram #(.N(N)) u_ram (
    .clk     (clk),
    .i_wsel  (r_wsel),
    .i_waddr (w_waddr),
    .i_wdata (ip),
    .i_we    (w_we),
    .i_rsel  (r_rsel),
    .i_raddr (r_rcnt),
    .o_rdata (w_rdata)
  );

  // Write side: a start pulse always lands at index 0; the last index closes the frame.
  // The fill counter already points at the next index, so it is never 0 in W_FILL.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wcnt_nxt   = r_wcnt;
    w_wsel_nxt   = r_wsel;
    w_we         = 1'b0;
    w_waddr      = N'(bitrev(BITREV_MAX_N'(r_wcnt), N));
    w_req        = 1'b0;
    w_abort      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (start_ip) begin
          w_we         = 1'b1;
          w_waddr      = '0;
          w_wcnt_nxt   = N'(1);
          w_wstate_nxt = W_FILL;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_FILL: begin
        w_we = 1'b1;
        if (start_ip) begin
          // Restart mid-frame: discard the partial frame, same bank, index 0.
          w_abort    = 1'b1;
          w_waddr    = '0;
          w_wcnt_nxt = N'(1);
        end else if (r_wcnt == LAST_IDX) begin
          w_req        = 1'b1;
          w_wsel_nxt   = ~r_wsel;
          w_wcnt_nxt   = '0;
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt + N'(1);
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
        w_wcnt_nxt   = '0;
      end
    endcase
  end

  // Read side: a request from the write side arms a drain of the just-completed bank;
  // a request arriving on the final drain beat chains straight into the next drain.
  always_comb begin
    w_rstate_nxt   = r_rstate;
    w_rcnt_nxt     = r_rcnt;
    w_rsel_nxt     = r_rsel;
    w_op_nxt       = r_op;
    w_start_op_nxt = 1'b0;
    w_valid_op_nxt = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_req) begin
          w_rstate_nxt = R_DRAIN;
          w_rsel_nxt   = r_wsel;
          w_rcnt_nxt   = '0;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_DRAIN: begin
        w_op_nxt       = w_rdata;
        w_valid_op_nxt = 1'b1;
        w_start_op_nxt = (r_rcnt == '0);
        if (r_rcnt == LAST_IDX) begin
          w_rcnt_nxt = '0;
          if (w_req) begin
            w_rsel_nxt = r_wsel;
          end else begin
            w_rstate_nxt = R_IDLE;
          end
        end else begin
          w_rcnt_nxt = r_rcnt + N'(1);
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
        w_rcnt_nxt   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset leaves the banks untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate   <= W_IDLE;
      r_wcnt     <= '0;
      r_wsel     <= 1'b0;
      r_rstate   <= R_IDLE;
      r_rcnt     <= '0;
      r_rsel     <= 1'b0;
      r_op       <= '0;
      r_start_op <= 1'b0;
      r_valid_op <= 1'b0;
      r_abort_op <= 1'b0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_wsel     <= w_wsel_nxt;
      r_rstate   <= w_rstate_nxt;
      r_rcnt     <= w_rcnt_nxt;
      r_rsel     <= w_rsel_nxt;
      r_op       <= w_op_nxt;
      r_start_op <= w_start_op_nxt;
      r_valid_op <= w_valid_op_nxt;
      r_abort_op <= w_abort;
    end
  end

  assign op       = r_op;
  assign start_op = r_start_op;
  assign valid_op = r_valid_op;
  assign abort_op = r_abort_op;

endmodule
